// File: rtl/div_unit_pkg.sv
// div_unit_pkg: shared widths, constants and op encodings for the divider.
package div_unit_pkg;
   localparam int XLEN  = 32;
   localparam int CNT_W = 6;
   localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};
   typedef enum logic [1:0] {
      DIV_DIV  = 2'd0,
      DIV_DIVU = 2'd1,
      DIV_REM  = 2'd2,
      DIV_REMU = 2'd3
   } div_op_e;
endpackage

// File: rtl/div_unit_if.sv
// div_unit_if: start/busy/valid handshake and operand/result bus of the divider.
interface div_unit_if;
   import div_unit_pkg::*;
   logic            start;
   logic            flush;
   div_op_e         op;
   logic [XLEN-1:0] a;
   logic [XLEN-1:0] b;
   logic            busy;
   logic            valid;
   logic [XLEN-1:0] result;
   modport master (output start, flush, op, a, b, input busy, valid, result);
   modport slave  (input start, flush, op, a, b, output busy, valid, result);
endinterface

// File: rtl/div_unit_step.sv
// div_unit_step: one restoring-division iteration producing a quotient bit.
module div_unit_step
   import div_unit_pkg::*;
(
   input  logic [XLEN-1:0] rem_i,
   input  logic            bit_i,
   input  logic [XLEN-1:0] dvs_i,
   output logic [XLEN-1:0] rem_o,
   output logic            q_o
);
   // XLEN+1-bit partial remainder so the trial subtraction keeps its borrow
   logic [XLEN:0] pr;
   assign pr    = {rem_i, bit_i};
   assign q_o   = pr >= {1'b0, dvs_i};
   assign rem_o = q_o ? XLEN'(pr - {1'b0, dvs_i}) : pr[XLEN-1:0];
endmodule

// File: rtl/div_unit.sv
// div_unit: multi-cycle RISC-V DIV/DIVU/REM/REMU, restoring, one quotient bit per cycle.
module div_unit
   import div_unit_pkg::*;
(
   input  logic      clk,
   input  logic      rst_n,
   div_unit_if.slave bus
);
   typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_e;
   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [XLEN-1:0]  rem_q, rem_d, dvd_q, dvd_d, dvs_q, dvs_d, result_q, result_d;
   logic             rem_sel_q, rem_sel_d, neg_quo_q, neg_quo_d, neg_rem_q, neg_rem_d;
   logic             sgn, a_neg, b_neg, div0, ovf, st_q;
   logic [XLEN-1:0]  a_mag, b_mag, spec_res, quo_fin, fix_res, st_rem;
   assign sgn      = bus.op == DIV_DIV || bus.op == DIV_REM;
   assign a_neg    = sgn && bus.a[XLEN-1];
   assign b_neg    = sgn && bus.b[XLEN-1];
   assign a_mag    = a_neg ? -bus.a : bus.a;
   assign b_mag    = b_neg ? -bus.b : bus.b;
   assign div0     = bus.b == '0;
   assign ovf      = sgn && bus.a == INT_MIN && bus.b == '1;
   assign spec_res = bus.op[1] ? (div0 ? bus.a : '0) : (div0 ? '1 : INT_MIN);
   // dvd_q shifts dividend bits out the top while quotient bits fill the bottom
   div_unit_step u_step (
      .rem_i(rem_q),
      .bit_i(dvd_q[XLEN-1]),
      .dvs_i(dvs_q),
      .rem_o(st_rem),
      .q_o  (st_q)
   );
   assign quo_fin = {dvd_q[XLEN-2:0], st_q};
   assign fix_res = rem_sel_q ? (neg_rem_q ? -st_rem : st_rem) : (neg_quo_q ? -quo_fin : quo_fin);
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      rem_d     = rem_q;
      dvd_d     = dvd_q;
      dvs_d     = dvs_q;
      result_d  = result_q;
      rem_sel_d = rem_sel_q;
      neg_quo_d = neg_quo_q;
      neg_rem_d = neg_rem_q;
      if (state_q == S_IDLE) begin
         if (bus.start && !bus.flush) begin
            rem_sel_d = bus.op[1];
            neg_quo_d = a_neg ^ b_neg;
            neg_rem_d = a_neg;
            dvd_d     = a_mag;
            dvs_d     = b_mag;
            rem_d     = '0;
            cnt_d     = '0;
            state_d   = (div0 || ovf) ? S_DONE : S_CALC;
            result_d  = (div0 || ovf) ? spec_res : result_q;
         end
      end else if (bus.flush) begin
         state_d = S_IDLE;
         cnt_d   = '0;
      end else if (state_q == S_CALC) begin
         rem_d = st_rem;
         dvd_d = quo_fin;
         if (cnt_q == CNT_W'(31)) begin
            cnt_d    = '0;
            state_d  = S_DONE;
            result_d = fix_res;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end else begin
         state_d = S_IDLE;
      end
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         rem_q     <= '0;
         dvd_q     <= '0;
         dvs_q     <= '0;
         result_q  <= '0;
         rem_sel_q <= 1'b0;
         neg_quo_q <= 1'b0;
         neg_rem_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         rem_q     <= rem_d;
         dvd_q     <= dvd_d;
         dvs_q     <= dvs_d;
         result_q  <= result_d;
         rem_sel_q <= rem_sel_d;
         neg_quo_q <= neg_quo_d;
         neg_rem_q <= neg_rem_d;
      end
   end
   assign bus.busy   = state_q != S_IDLE;
   assign bus.valid  = state_q == S_DONE;
   assign bus.result = result_q;
endmodule
